pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; WIDTH SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 2, number of pipeline stages (1..8); each stage SHALL add one WIDTH/STAGES-bit slice.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 y  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry  output  1  carry-out of the top bit.
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  y == 0.
REQ-016 negative  output  1  y[WIDTH-1].

Function
REQ-017 Effective operation SHALL be A + (sub ? ~B : B) + sub, computed in WIDTH+1 bits; carry = bit WIDTH.
REQ-018 Subtract carry SHALL be "no borrow": carry=1 iff A >= B unsigned.
REQ-019 overflow SHALL be 1 iff A[MSB] equals effective-B[MSB] and y[MSB] differs from it.
REQ-020 Stage k SHALL register slice k sum, slice k carry-out, the already-summed lower slices, and the unconsumed upper operand slices plus sub; the slice carry SHALL feed slice k+1 in the next stage only.
REQ-021 Beat transfers in when in_valid && in_ready; beat transfers out when out_valid && out_ready.
REQ-022 Pipeline enable en = ~out_valid | out_ready; all stages advance together when en=1, hold when en=0.
REQ-023 in_ready SHALL equal en, combinationally; no combinational path from in_valid, a, b or sub to any output.
REQ-024 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one beat per cycle.
REQ-025 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages, not be collapsed.
REQ-026 While out_valid=1 and out_ready=0, y and all flags SHALL be stable.
REQ-027 Simultaneous in and out transfer in one cycle SHALL lose no beat and reorder none.
REQ-028 Results SHALL emerge in acceptance order.

Reset
REQ-029 With rst=1 at a rising edge, every stage valid bit SHALL clear; out_valid=0, y=0, carry=overflow=zero=negative=0 on the following cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after rst deasserts.
REQ-031 During rst=1, in_ready SHALL be 0; first transfer possible the cycle after rst falls.

Structure
REQ-032 Package pipe_addsub_pkg SHALL hold the flags struct (carry, overflow, zero, negative) and the STAGES range constants.
REQ-033 One sub-module addsub_slice (parameter SW; inputs a, b, cin; outputs sum, cout) SHALL be instantiated per stage.
REQ-034 Flags SHALL be derived in the final stage from registered data only.

Verification (WIDTH=32, STAGES=2)
REQ-035 Add 0x7FFFFFFF+0x00000001, sub=0 -> 2 cycles later y=0x80000000, carry=0, overflow=1, negative=1, zero=0.
REQ-036 Sub 0x00000005-0x00000005 -> y=0, carry=1, overflow=0, zero=1; sub 0x00000000-0x00000001 -> y=0xFFFFFFFF, carry=0, overflow=0.
REQ-037 Back-to-back 8 beats with out_ready=1 -> 8 consecutive out_valid cycles starting cycle 2, results in order.
REQ-038 Hold out_ready=0 for 4 cycles with pipe full -> in_ready=0, y/flags stable; release -> no loss or duplication.
REQ-039 Assert rst with 2 beats in flight -> out_valid=0 next cycle, no stale beat emerges after rst falls.
REQ-040 Slice-boundary carry: 0x0000FFFF+0x00000001 -> y=0x00010000, carry=0; repeat with STAGES=1 and 4 for identical results.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg
//   Shared declarations for the pipelined adder/subtractor:
//   - flags_t      : registered result flags (carry, overflow, zero, negative)
//   - STAGES_MIN/MAX: supported range of the STAGES parameter
//   - slice_width(): width of the slice each pipeline stage adds
package pipe_addsub_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice
//   One SW-bit ripple slice: {cout, sum} = a + b + cin.
//   Ports:
//     a, b  [SW-1:0]  slice operands (b already conditionally inverted)
//     cin             carry into the slice
//     sum   [SW-1:0]  slice sum
//     cout            carry out of the slice
module addsub_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign sum    = w_full[SW-1:0];
    assign cout   = w_full[SW];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub
//   Pipelined WIDTH-bit add/subtract. Stage k adds operand slice k
//   (WIDTH/STAGES bits); the slice carry is registered and consumed by the
//   next stage, so the critical path is one slice adder per stage.
//   Result = A + (sub ? ~B : B) + sub, with carry (no-borrow on subtract),
//   signed overflow, zero and negative flags registered in the last stage.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        operand handshake; a, b, sub operands
//     out_valid/out_ready      result handshake
//     y, carry, overflow, zero, negative   result and flags
//
// Handshake: a beat moves in when in_valid && in_ready and out when
// out_valid && out_ready. All stages share one enable
// en = ~out_valid | out_ready; in_ready = en (forced low in reset). Outputs
// depend on registers only, so they hold steady while out_ready is low.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW = slice_width(WIDTH, STAGES);

    logic w_en;
    logic r_out_valid;

    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en & ~rst;

    // Intermediate stages 0 .. STAGES-2. Each keeps the low result bits
    // summed so far plus only the operand bits not yet consumed.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
        localparam int DW = (k + 1) * SW;  // result bits complete after this stage
        localparam int UW = WIDTH - DW;    // operand bits still to be added

        logic [SW-1:0] w_a_sl, w_b_raw, w_b_eff, w_sum_sl;
        logic          w_sub, w_cin, w_vin, w_cout;
        logic [DW-1:0] w_sum_next;
        logic [UW-1:0] w_a_rest, w_b_rest;

        logic          r_valid, r_sub, r_cout;
        logic [DW-1:0] r_sum;
        logic [UW-1:0] r_a_up, r_b_up;

        if (k == 0) begin : g_src
            assign w_a_sl     = a[SW-1:0];
            assign w_b_raw    = b[SW-1:0];
            assign w_a_rest   = a[WIDTH-1:SW];
            assign w_b_rest   = b[WIDTH-1:SW];
            assign w_sub      = sub;
            assign w_cin      = sub;      // the +1 of two's-complement negate
            assign w_vin      = in_valid;
            assign w_sum_next = w_sum_sl;
        end else begin : g_src
            assign w_a_sl     = g_st[k-1].r_a_up[SW-1:0];
            assign w_b_raw    = g_st[k-1].r_b_up[SW-1:0];
            assign w_a_rest   = g_st[k-1].r_a_up[UW+SW-1:SW];
            assign w_b_rest   = g_st[k-1].r_b_up[UW+SW-1:SW];
            assign w_sub      = g_st[k-1].r_sub;
            assign w_cin      = g_st[k-1].r_cout;
            assign w_vin      = g_st[k-1].r_valid;
            assign w_sum_next = {w_sum_sl, g_st[k-1].r_sum};
        end

        assign w_b_eff = w_sub ? ~w_b_raw : w_b_raw;

        addsub_slice #(.SW(SW)) u_slice (
            .a    (w_a_sl),
            .b    (w_b_eff),
            .cin  (w_cin),
            .sum  (w_sum_sl),
            .cout (w_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sub   <= 1'b0;
                r_cout  <= 1'b0;
                r_sum   <= '0;
                r_a_up  <= '0;
                r_b_up  <= '0;
            end else if (w_en) begin
                // Bubbles advance as invalid stages; data is don't-care then.
                r_valid <= w_vin;
                r_sub   <= w_sub;
                r_cout  <= w_cout;
                r_sum   <= w_sum_next;
                r_a_up  <= w_a_rest;
                r_b_up  <= w_b_rest;
            end
        end
    end

    // Final stage: top slice, full result and flags.
    logic [SW-1:0]    w_fa, w_fb_raw, w_fb_eff, w_fsum;
    logic             w_fsub, w_fcin, w_fvin, w_fcout;
    logic [WIDTH-1:0] w_y_next;
    flags_t           w_flags_next;

    logic [WIDTH-1:0] r_y;
    flags_t           r_flags;

    if (STAGES == 1) begin : g_last_src
        assign w_fa     = a;
        assign w_fb_raw = b;
        assign w_fsub   = sub;
        assign w_fcin   = sub;
        assign w_fvin   = in_valid;
        assign w_y_next = w_fsum;
    end else begin : g_last_src
        assign w_fa     = g_st[STAGES-2].r_a_up;
        assign w_fb_raw = g_st[STAGES-2].r_b_up;
        assign w_fsub   = g_st[STAGES-2].r_sub;
        assign w_fcin   = g_st[STAGES-2].r_cout;
        assign w_fvin   = g_st[STAGES-2].r_valid;
        assign w_y_next = {w_fsum, g_st[STAGES-2].r_sum};
    end

    assign w_fb_eff = w_fsub ? ~w_fb_raw : w_fb_raw;

    addsub_slice #(.SW(SW)) u_slice_last (
        .a    (w_fa),
        .b    (w_fb_eff),
        .cin  (w_fcin),
        .sum  (w_fsum),
        .cout (w_fcout)
    );

    always_comb begin
        w_flags_next          = '0;
        w_flags_next.carry    = w_fcout;
        // Signed overflow: operand signs agree but the result sign differs.
        w_flags_next.overflow = (w_fa[SW-1] == w_fb_eff[SW-1]) &&
                                (w_fsum[SW-1] != w_fa[SW-1]);
        w_flags_next.zero     = (w_y_next == '0);
        w_flags_next.negative = w_fsum[SW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
        end else if (w_en) begin
            r_out_valid <= w_fvin;
            // Idle outputs read as all-zero rather than bubble garbage.
            r_y         <= w_fvin ? w_y_next : '0;
            r_flags     <= w_fvin ? w_flags_next : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign carry     = r_flags.carry;
    assign overflow  = r_flags.overflow;
    assign zero      = r_flags.zero;
    assign negative  = r_flags.negative;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub
//   Drives three pipe_addsub instances (STAGES = 2, 1, 4; WIDTH = 32) from
//   shared operand inputs. A behavioural model computes each accepted beat's
//   result with plain signed/unsigned arithmetic; a compare process checks
//   every presented output beat, in order, against per-instance expected
//   queues. Directed vectors also pin latency and literal results.
module tb_pipe_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic        sub;
    logic        out_ready;
    logic        out_ready_fast;

    logic        in_ready2, out_valid2, c2, ov2, z2, n2;
    logic [31:0] y2;
    logic        in_ready1, out_valid1, c1, ov1, z1, n1;
    logic [31:0] y1;
    logic        in_ready4, out_valid4, c4, ov4, z4, n4;
    logic [31:0] y4;
    logic [35:0] pack2, pack1, pack4;

    logic [35:0] exp_q2[$];
    logic [35:0] exp_q1[$];
    logic [35:0] exp_q4[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign out_ready_fast = 1'b1;
    assign pack2 = {y2, c2, ov2, z2, n2};
    assign pack1 = {y1, c1, ov1, z1, n1};
    assign pack4 = {y4, c4, ov4, z4, n4};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .carry(c2), .overflow(ov2), .zero(z2), .negative(n2)
    );

    pipe_addsub #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready_fast),
        .y(y1), .carry(c1), .overflow(ov1), .zero(z1), .negative(n1)
    );

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid4), .out_ready(out_ready_fast),
        .y(y4), .carry(c4), .overflow(ov4), .zero(z4), .negative(n4)
    );

    // ---------------- model ----------------
    // Returns {y, carry, overflow, zero, negative}.
    function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms);
        longint ua   = longint'({32'd0, ma});
        longint ub   = longint'({32'd0, mb});
        longint sa   = longint'($signed(ma));
        longint sb   = longint'($signed(mb));
        longint smax = 2147483647;
        longint smin = -smax - 1;
        longint ur, sr;
        logic [31:0] my;
        logic mc, mv;
        if (ms) begin
            ur = ua - ub;
            sr = sa - sb;
            mc = (ma >= mb);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            mc = (ur > longint'({32'd0, 32'hFFFF_FFFF}));
        end
        my = ur[31:0];
        mv = (sr > smax) || (sr < smin);
        return {my, mc, mv, (my == 32'd0), my[31]};
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (out_valid2) begin
            if (exp_q2.size() == 0) chk_bit("s2_spurious_beat", out_valid2, 1'b0);
            else begin
                chk_vec("s2_result", pack2, exp_q2[0]);
                if (out_ready) void'(exp_q2.pop_front());
            end
        end
        if (out_valid1) begin
            if (exp_q1.size() == 0) chk_bit("s1_spurious_beat", out_valid1, 1'b0);
            else begin
                chk_vec("s1_result", pack1, exp_q1[0]);
                void'(exp_q1.pop_front());
            end
        end
        if (out_valid4) begin
            if (exp_q4.size() == 0) chk_bit("s4_spurious_beat", out_valid4, 1'b0);
            else begin
                chk_vec("s4_result", pack4, exp_q4[0]);
                void'(exp_q4.pop_front());
            end
        end
        if (rst) begin
            chk_bit("rst_in_ready", in_ready2, 1'b0);
            exp_q2.delete();
            exp_q1.delete();
            exp_q4.delete();
        end else begin
            if (in_valid && in_ready2) exp_q2.push_back(model(a, b, sub));
            if (in_valid && in_ready1) exp_q1.push_back(model(a, b, sub));
            if (in_valid && in_ready4) exp_q4.push_back(model(a, b, sub));
        end
    end

    // ---------------- driver tasks ----------------
    // One beat into an empty pipe with out_ready high; checks the exact
    // latency of every instance and the hand-computed literal result.
    task automatic dir_vec(input string nm, input logic [31:0] va, input logic [31:0] vb,
                           input logic vs, input logic [35:0] exp);
        chk_vec({nm, "_model"}, model(va, vb, vs), exp);
        a = va;
        b = vb;
        sub = vs;
        in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) in_valid = 1'b0;
            chk_bit({nm, "_s1_valid"}, out_valid1, c == 1);
            chk_bit({nm, "_s2_valid"}, out_valid2, c == 2);
            chk_bit({nm, "_s4_valid"}, out_valid4, c == 4);
            if (c == 1) chk_vec({nm, "_s1"}, pack1, exp);
            if (c == 2) chk_vec({nm, "_s2"}, pack2, exp);
            if (c == 4) chk_vec({nm, "_s4"}, pack4, exp);
        end
    endtask

    logic [31:0] st_a [3] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] st_b [3] = '{32'h1234_5678, 32'h0000_0002, 32'h8000_0000};
    logic [2:0]  st_s     = 3'b101;
    logic        acc;
    int          k;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_bit("reset_out_valid", out_valid2, 1'b0);
        chk_vec("reset_outputs", pack2, 36'd0);
        chk_bit("reset_in_ready", in_ready2, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("post_reset_in_ready", in_ready2, 1'b1);

        // {y, carry, overflow, zero, negative}
        dir_vec("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 4'b0101});
        dir_vec("sub_eq",    32'h0000_0005, 32'h0000_0005, 1'b1, {32'h0000_0000, 4'b1010});
        dir_vec("sub_borrow",32'h0000_0000, 32'h0000_0001, 1'b1, {32'hFFFF_FFFF, 4'b0001});
        dir_vec("slice_cy",  32'h0000_FFFF, 32'h0000_0001, 1'b0, {32'h0001_0000, 4'b0000});
        dir_vec("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 4'b1010});
        dir_vec("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 4'b1100});

        // Back-to-back: 8 beats, results on 8 consecutive cycles from cycle 2.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                a = 32'h7FFF_FFF0 + 32'(c) * 32'h0001_0001;
                b = 32'h0000_0010 + 32'(c * 7);
                sub = c[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk_bit("b2b_in_ready", in_ready2, 1'b1);
            chk_bit("b2b_out_valid", out_valid2, (c >= 2) && (c < 10));
            @(posedge clk);
            #1;
        end

        // Stall: out_ready low with the pipe full.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 3) begin
                a = st_a[k];
                b = st_b[k];
                sub = st_s[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready2;
            if (c >= 2) begin
                chk_bit("stall_in_ready", in_ready2, 1'b0);
                chk_bit("stall_out_valid", out_valid2, 1'b1);
            end
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        chk_vec("stall_held_count", 36'(k), 36'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (k < 3) begin
                a = st_a[k];
                b = st_b[k];
                sub = st_s[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready2;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        chk_vec("stall_accepted", 36'(k), 36'd3);
        chk_vec("stall_drained", 36'(exp_q2.size()), 36'd0);

        // Reset with two beats in flight.
        for (int c = 0; c < 2; c++) begin
            a = 32'h0102_0304 << c;
            b = 32'h0000_FFFF;
            sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("midrst_s2_valid", out_valid2, 1'b0);
        chk_bit("midrst_s1_valid", out_valid1, 1'b0);
        chk_bit("midrst_s4_valid", out_valid4, 1'b0);
        chk_vec("midrst_outputs", pack2, 36'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        dir_vec("after_rst", 32'h0000_0003, 32'h0000_0007, 1'b1, {32'hFFFF_FFFC, 4'b0001});

        repeat (2) @(posedge clk);
        #1;
        chk_vec("end_q2_empty", 36'(exp_q2.size()), 36'd0);
        chk_vec("end_q1_empty", 36'(exp_q1.size()), 36'd0);
        chk_vec("end_q4_empty", 36'(exp_q4.size()), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
